// File: rtl/muldiv_seq_pkg.sv
// Shared types for the iterative RV64M multiply/divide sequencer.
package muldiv_seq_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [3:0] {
    MD_MUL   = 4'd0,
    MD_MULW  = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_REM   = 4'd4,
    MD_REMU  = 4'd5,
    MD_DIVW  = 4'd6,
    MD_DIVUW = 4'd7,
    MD_REMW  = 4'd8,
    MD_REMUW = 4'd9
  } mdfunc_t;

  typedef logic [1:0] mdstate_t;
  localparam mdstate_t IDLE = 2'd0;
  localparam mdstate_t BUSY = 2'd1;
  localparam mdstate_t DONE = 2'd2;

  function automatic u64 sext32(input u32 v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module muldiv_core
  import muldiv_seq_pkg::*;
(
  input  logic mul,
  input  u64   acc,
  input  u64   x,
  input  u64   y,
  output u64   acc_next,
  output u64   x_next,
  output u64   y_next
);

  logic [64:0] sh;
  u64          sub;
  logic        ge;

  always_comb begin
    sh       = {acc, x[63]};
    ge       = (sh >= {1'b0, y});
    sub      = sh[63:0] - y;
    acc_next = acc;
    x_next   = x;
    y_next   = y;
    if (mul) begin
      // acc accumulates the low product bits; x is the shifted multiplicand
      acc_next = acc + (y[0] ? x : '0);
      x_next   = {x[62:0], 1'b0};
      y_next   = {1'b0, y[63:1]};
    end else begin
      // x carries the dividend out of its top and quotient bits in at the bottom
      acc_next = ge ? sub : sh[63:0];
      x_next   = {x[62:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer with valid/ready on both sides.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdfunc_t         op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam u64 MIN_D = 64'h8000_0000_0000_0000;
  localparam u64 MIN_W = 64'hFFFF_FFFF_8000_0000;

  mdstate_t   state;
  logic [6:0] cnt;
  logic       mul_op, w_op, rem_op, neg_quo, neg_rem;
  u64         acc, x, y;
  u64         acc_next, x_next, y_next;

  logic is_w, is_div, is_sgn, is_rem, a_neg, b_neg, div_zero, ovf;
  u64   a_ext, b_ext, a_mag, b_mag, special, raw, final_res;

  function automatic u64 neg_if(input logic c, input u64 v);
    return c ? (~v + 64'd1) : v;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  muldiv_core u_core (
    .mul      (mul_op),
    .acc      (acc),
    .x        (x),
    .y        (y),
    .acc_next (acc_next),
    .x_next   (x_next),
    .y_next   (y_next)
  );

  // Request decode: operand extension, signs, magnitudes and early-out cases
  always_comb begin
    is_w   = op inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
    is_div = op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU,
                        MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
    is_sgn = op inside {MD_DIV, MD_REM, MD_DIVW, MD_REMW};
    is_rem = op inside {MD_REM, MD_REMU, MD_REMW, MD_REMUW};
    a_ext  = is_w ? (is_sgn ? sext32(rs1[31:0]) : {32'b0, rs1[31:0]}) : rs1;
    b_ext  = is_w ? (is_sgn ? sext32(rs2[31:0]) : {32'b0, rs2[31:0]}) : rs2;
    a_neg  = is_sgn & a_ext[63];
    b_neg  = is_sgn & b_ext[63];
    a_mag  = neg_if(a_neg, a_ext);
    b_mag  = neg_if(b_neg, b_ext);
    div_zero = is_div && (b_ext == '0);
    ovf      = is_sgn && (b_ext == '1) && (a_ext == (is_w ? MIN_W : MIN_D));
    // Overflow quotient is the dividend itself (MIN), remainder is zero
    if (div_zero) special = is_rem ? a_ext : '1;
    else          special = is_rem ? '0 : a_ext;
    if (is_w) special = sext32(special[31:0]);
  end

  always_comb begin
    if (mul_op)      raw = acc_next;
    else if (rem_op) raw = neg_if(neg_rem, acc_next);
    else             raw = neg_if(neg_quo, x_next);
    final_res = w_op ? sext32(raw[31:0]) : raw;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mul_op  <= 1'b0;
      w_op    <= 1'b0;
      rem_op  <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      x       <= '0;
      y       <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_op  <= !is_div;
            w_op    <= is_w;
            rem_op  <= is_rem;
            neg_quo <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            acc     <= '0;
            // W divides start with the 32-bit dividend at the top of x
            x       <= (is_div && is_w) ? {a_mag[31:0], 32'b0} : a_mag;
            y       <= b_mag;
            if (div_zero || ovf) begin
              result <= special;
              state  <= DONE;
            end else begin
              cnt   <= is_w ? 7'd32 : 7'd64;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= acc_next;
          x   <= x_next;
          y   <= y_next;
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            result <= final_res;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  logic    flush = 1'b0;
  logic    in_valid = 1'b0;
  logic    out_ready = 1'b0;
  mdfunc_t op = MD_MUL;
  u64      rs1 = '0;
  u64      rs2 = '0;
  logic    in_ready, out_valid;
  u64      result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  function automatic u64 w32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic u64 model(input mdfunc_t o, input u64 a, input u64 b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    u64          r;
    logic        ovf64, ovf32;
    sa = a; sb = b; ua32 = a[31:0]; ub32 = b[31:0]; sa32 = ua32; sb32 = ub32;
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    ovf32 = (ua32 == 32'h8000_0000) && (ub32 == 32'hFFFF_FFFF);
    case (o)
      MD_MULW: begin r32 = ua32 * ub32; r = w32(r32); end
      MD_DIV:  if (b == 0) r = '1; else if (ovf64) r = a; else r = sa / sb;
      MD_DIVU: if (b == 0) r = '1; else r = a / b;
      MD_REM:  if (b == 0) r = a;  else if (ovf64) r = '0; else r = sa % sb;
      MD_REMU: if (b == 0) r = a;  else r = a % b;
      MD_DIVW: begin
        if (ub32 == 0) r32 = '1; else if (ovf32) r32 = ua32; else r32 = sa32 / sb32;
        r = w32(r32);
      end
      MD_DIVUW: begin
        if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
        r = w32(r32);
      end
      MD_REMW: begin
        if (ub32 == 0) r32 = ua32; else if (ovf32) r32 = '0; else r32 = sa32 % sb32;
        r = w32(r32);
      end
      MD_REMUW: begin
        if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
        r = w32(r32);
      end
      default: r = a * b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input mdfunc_t o, input u64 a, input u64 b);
    bit w, dv, sg;
    w  = o inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
    dv = o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
    sg = o inside {MD_DIV, MD_REM, MD_DIVW, MD_REMW};
    if (dv && w && (b[31:0] == 0)) return 1;
    if (dv && !w && (b == 0)) return 1;
    if (sg && w && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
    if (sg && !w && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return w ? 33 : 65;
  endfunction

  // Called at posedge+1 right after the accept edge; counts cycles to out_valid.
  task automatic wait_done(output int lat, output bit rdy_seen);
    lat = 1; rdy_seen = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic retire;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input mdfunc_t o, input u64 a, input u64 b,
                        output u64 r, output int lat, output bit rdy_seen);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat, rdy_seen);
    r = result;
    retire();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h want 1 0 0", in_ready, out_valid, result);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    u64 r; int lat; bit rdy;
    run_op(MD_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, r, lat, rdy);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mul_result got %h want fffffffffffffff1", r); end
    checks++;
    if (lat != 65) begin errors++; $display("FAIL mul_latency got %0d want 65", lat); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy got %b want 0", rdy); end
  endtask

  task automatic test_div;
    mdfunc_t ops[4] = '{MD_DIV, MD_REM, MD_DIVU, MD_REMU};
    u64 as[4]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100};
    u64 bs[4]  = '{64'd2, 64'd2, 64'd7, 64'd7};
    u64 exp[4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'd2};
    u64 r; int lat; bit rdy;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, rdy);
      checks++;
      if (r !== exp[i] || lat != 65) begin
        errors++;
        $display("FAIL div_case%0d got %h lat %0d want %h lat 65", i, r, lat, exp[i]);
      end
    end
  endtask

  task automatic test_special;
    mdfunc_t ops[5] = '{MD_DIVU, MD_REM, MD_DIVW, MD_DIV, MD_REMW};
    u64 as[5]  = '{64'd5, 64'h1234, 64'h8000_0000, 64'h8000_0000_0000_0000, 64'hABCD_0000_8000_0005};
    u64 bs[5]  = '{64'd0, 64'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111_1111_0000_0000};
    u64 exp[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'hFFFF_FFFF_8000_0000,
                   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0005};
    u64 r; int lat; bit rdy;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, rdy);
      checks++;
      if (r !== exp[i] || lat != 1) begin
        errors++;
        $display("FAIL special_case%0d got %h lat %0d want %h lat 1", i, r, lat, exp[i]);
      end
    end
  endtask

  task automatic test_mulw;
    u64 r; int lat; bit rdy;
    run_op(MD_MULW, 64'h7FFF_FFFF, 64'd2, r, lat, rdy);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || lat != 33) begin
      errors++; $display("FAIL mulw got %h lat %0d want fffffffffffffffe lat 33", r, lat);
    end
    run_op(MD_MULW, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, r, lat, rdy);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || lat != 33) begin
      errors++; $display("FAIL mulw_garbage got %h lat %0d want fffffffffffffffe lat 33", r, lat);
    end
  endtask

  task automatic test_backpressure;
    int lat; bit rdy;
    op = MD_DIVU; rs1 = 64'd100; rs2 = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat, rdy);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 64'd14}) begin
        errors++;
        $display("FAIL hold_cycle%0d got vld=%b rdy=%b res=%h want 1 0 e", i, out_valid, in_ready, result);
      end
      @(posedge clk); #1;
    end
    // request offered during the retiring cycle must wait for IDLE
    out_ready = 1'b1; in_valid = 1'b1; op = MD_MUL; rs1 = 64'd6; rs2 = 64'd7;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL retire_to_idle got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL accept_after_idle got rdy=%b want 0", in_ready); end
    wait_done(lat, rdy);
    checks++;
    if (result !== 64'd42 || lat != 65) begin
      errors++; $display("FAIL bp_next_op got %h lat %0d want 2a lat 65", result, lat);
    end
    retire();
  endtask

  task automatic test_flush;
    int seen; u64 r; int lat; bit rdy;
    op = MD_DIV; rs1 = 64'd1000000; rs2 = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1; op = MD_MUL; rs1 = 64'd2; rs2 = 64'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL flush_busy got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_reject got rdy=%b want 1", in_ready); end
    op = MD_DIVU; rs1 = 64'd9; rs2 = 64'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL flush_done got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    run_op(MD_DIV, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, r, lat, rdy);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FF72 || lat != 65) begin
      errors++; $display("FAIL div_after_flush got %h lat %0d want ffffffffffffff72 lat 65", r, lat);
    end
  endtask

  task automatic test_reset_busy;
    int seen; u64 r; int lat; bit rdy;
    op = MD_MUL; rs1 = 64'd5; rs2 = 64'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset_busy got rdy=%b vld=%b res=%h want 1 0 0", in_ready, out_valid, result);
    end
    reset = 1'b1;
    seen = 0;
    repeat (70) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_no_result got %0d valid cycles want 0", seen); end
    run_op(MD_MUL, 64'd5, 64'd5, r, lat, rdy);
    checks++;
    if (r !== 64'd25) begin errors++; $display("FAIL mul_after_reset got %h want 19", r); end
  endtask

  function automatic u64 pick_operand();
    u64 specials[7] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                        64'h8000_0000, 64'hFFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return u64'(longint'($urandom_range(0, 200)) - 64'sd100);
      2:       return specials[$urandom_range(0, 6)];
      default: return {$urandom, 32'($urandom_range(0, 50))};
    endcase
  endfunction

  task automatic test_random;
    u64 a, b, r, exp; int lat, el; bit rdy; logic [3:0] code; mdfunc_t o;
    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom_range(0, 9));
      o = mdfunc_t'(code);
      a = pick_operand(); b = pick_operand();
      exp = model(o, a, b); el = exp_lat(o, a, b);
      run_op(o, a, b, r, lat, rdy);
      checks++;
      if (r !== exp || lat != el) begin
        errors++;
        $display("FAIL random%0d op=%0d a=%h b=%h got %h lat %0d want %h lat %0d", i, code, a, b, r, lat, exp, el);
      end
    end
    code = 4'd13;
    run_op(mdfunc_t'(code), 64'd6, 64'd7, r, lat, rdy);
    checks++;
    if (r !== 64'd42 || lat != 65) begin
      errors++; $display("FAIL unknown_op got %h lat %0d want 2a lat 65", r, lat);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_mulw();
    test_backpressure();
    test_flush();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV64M multiply/divide sequencer in the execute stage, next to the single-cycle alu.
- Takes one operation at a time over a valid/ready handshake, runs a radix-2 shift-add multiply or restoring divide, and holds the result until the pipeline accepts it.
- While busy, in_ready stays low; the execute stage uses it as its stall source for M-extension instructions.

Parameters:
- XLEN, 64, operand/result width. Only 64 is supported; W ops use the low 32 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- flush  in  1  pipeline flush; aborts any operation
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  mdfunc_t  operation code
- rs1  in  XLEN  operand a
- rs2  in  XLEN  operand b
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  XLEN  final result, sign-extended for W ops

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, in_ready=1, out_valid=0, result=0.
  - All internal registers cleared.
  - Overrides flush and any in-flight operation.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch op and operands.
  - W ops: operands are the low 32 bits, sign- or zero-extended per signedness.
  - Signed ops: record result sign, then work on magnitudes.
  - Special cases go straight to DONE; everything else goes to BUSY with cnt=N (N=64 for 64-bit ops, 32 for W ops).
- BUSY:
  - One iteration per cycle; cnt decrements; goes to DONE when cnt reaches 1.
  - Multiply keeps only the low XLEN bits of the product.
  - Divide is restoring, one quotient bit per cycle.
- DONE:
  - out_valid=1; result is stable and held until out_ready.
  - On out_valid&out_ready, go to IDLE. The unit does not accept a new request in that same cycle.
- Latency: out_valid rises N+1 cycles after the accept edge (65 cycles for 64-bit ops, 33 for W ops). Special cases: 1 cycle.
- Special cases:
  - Divide by zero: quotient = all ones; remainder = dividend (W: sign-extended low 32 bits).
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - For W ops, MIN is 0x80000000 and the result is sign-extended.
- Sign rules:
  - Quotient is negated when operand signs differ.
  - Remainder takes the dividend's sign.
- MULW, DIVW, DIVUW, REMW, REMUW: compute 32-bit result r, output {{32{r[31]}}, r[31:0]}.
- flush=1 at posedge (reset inactive):
  - Next state IDLE, out_valid=0 in the following cycle.
  - Any in-flight or held result is discarded.
  - A request presented in the same cycle is not accepted.
- in_ready=1 only in IDLE. Request fields are don't-care when in_valid=0.
- Unknown op: treated as MUL. In the spec for completeness; the decoder never issues it.

Decomposition:
- pipes package:
  - mdfunc_t enum: MD_MUL, MD_MULW, MD_DIV, MD_DIVU, MD_REM, MD_REMU, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW.
  - mdstate_t enum: IDLE, BUSY, DONE.
- common package: u64, u32.
- One natural sub-module, muldiv_core: combinational single iteration step (partial remainder/accumulator update and quotient bit). The sequencer owns state, counter, sign fix-up and the handshake.

Test Plan:
- MUL rs1=3, rs2=0xFFFFFFFFFFFFFFFB (-5), out_ready=1 → out_valid exactly 65 cycles after accept, result=0xFFFFFFFFFFFFFFF1; in_ready low throughout.
- DIV -7/2 → 0xFFFFFFFFFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFFFFFFFFFF (-1); DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU rs2=0 → result=0xFFFFFFFFFFFFFFFF after 1 cycle; REM rs1=0x1234, rs2=0 → 0x1234; DIVW rs1=0x80000000, rs2=0xFFFFFFFF → 0xFFFFFFFF80000000 after 1 cycle.
- MULW rs1=0x7FFFFFFF, rs2=2 → 0xFFFFFFFFFFFFFFFE, out_valid 33 cycles after accept; upper operand bits set to garbage → same result.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result and out_valid stable, in_ready=0; raise out_ready → IDLE next cycle, new request accepted the cycle after.
- Flush at BUSY cycle 20 → out_valid never rises for that op, in_ready=1 next cycle. reset=0 mid-BUSY → all outputs at reset values next cycle. Back-to-back DIV after flush gives the correct quotient.
